countdown_timer: RTL and testbench

//  Countdown engine fed by the microwave controller: loads minutes/seconds on start,

---
 rtl/countdown_timer_if.sv | 14 +
 rtl/countdown_timer.sv | 200 ++++++++++++++++++++
 tb/tb_countdown_timer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Command, setpoint and display bundle between the microwave controller and the countdown timer.
interface countdown_timer_if;
    logic       start;
    logic       stop;
    logic       pause;
    logic [6:0] min;
    logic [6:0] sec;
    logic       done;
    logic [7:0] an;
    logic [7:0] dec_cat;

    modport master (output start, stop, pause, min, sec, input done, an, dec_cat);
    modport slave  (input start, stop, pause, min, sec, output done, an, dec_cat);
endinterface

// File: rtl/countdown_timer.sv
// MM:SS countdown engine with run/pause/stop control and a 5-slot scanned 7-segment display.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic              clock,
    input  logic              reset,
    countdown_timer_if.slave  tmr
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [6:0]        cnt_min_q, cnt_min_d;
    logic [6:0]        cnt_sec_q, cnt_sec_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        slot_q, slot_d;
    logic              start_prev_q;
    logic              done_q, done_d;
    logic [7:0]        an_q, an_d;
    logic [7:0]        dec_cat_q, dec_cat_d;

    logic       start_rise;
    logic [6:0] sat_min, sat_sec;
    logic [6:0] disp_min, disp_sec;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        logic [3:0] t;
        t = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (v >= 7'(10 * i)) t = 4'(i);
        end
        return t;
    endfunction

    function automatic logic [3:0] bcd_units(input logic [6:0] v, input logic [3:0] t);
        return 4'(v - 7'(t) * 7'd10);
    endfunction

    // Active-low segments a..g for a decimal digit; anything else blanks.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign start_rise = tmr.start & ~start_prev_q;
    assign sat_min    = (tmr.min > 7'd99) ? 7'd99 : tmr.min;
    assign sat_sec    = (tmr.sec > 7'd59) ? 7'd59 : tmr.sec;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_min_q    <= '0;
            cnt_sec_q    <= '0;
            tick_cnt_q   <= '0;
            scan_cnt_q   <= '0;
            slot_q       <= '0;
            start_prev_q <= 1'b0;
            done_q       <= 1'b0;
            an_q         <= 8'hFF;
            dec_cat_q    <= 8'hFF;
        end else begin
            state_q      <= state_d;
            cnt_min_q    <= cnt_min_d;
            cnt_sec_q    <= cnt_sec_d;
            tick_cnt_q   <= tick_cnt_d;
            scan_cnt_q   <= scan_cnt_d;
            slot_q       <= slot_d;
            start_prev_q <= tmr.start;
            done_q       <= done_d;
            an_q         <= an_d;
            dec_cat_q    <= dec_cat_d;
        end
    end

    // Control FSM: stop > pause > start > tick.
    always_comb begin
        state_d    = state_q;
        cnt_min_d  = cnt_min_q;
        cnt_sec_d  = cnt_sec_q;
        tick_cnt_d = tick_cnt_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    tick_cnt_d = '0;
                    cnt_min_d  = sat_min;
                    cnt_sec_d  = sat_sec;
                    if ((sat_min == 7'd0) && (sat_sec == 7'd0)) done_d  = 1'b1;
                    else                                        state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tmr.stop) begin
                    state_d    = ST_IDLE;
                    cnt_min_d  = '0;
                    cnt_sec_d  = '0;
                    tick_cnt_d = '0;
                end else if (tmr.pause) begin
                    state_d = ST_PAUSED;
                end else if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    if (cnt_sec_q != 7'd0) begin
                        cnt_sec_d = cnt_sec_q - 7'd1;
                    end else if (cnt_min_q != 7'd0) begin
                        cnt_min_d = cnt_min_q - 7'd1;
                        cnt_sec_d = 7'd59;
                    end
                    if ((cnt_min_q == 7'd0) && (cnt_sec_q <= 7'd1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                end
            end
            ST_PAUSED: begin
                if (tmr.stop) begin
                    state_d    = ST_IDLE;
                    cnt_min_d  = '0;
                    cnt_sec_d  = '0;
                    tick_cnt_d = '0;
                end else if (tmr.pause || start_rise) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign disp_min  = (state_q == ST_IDLE) ? sat_min : cnt_min_q;
    assign disp_sec  = (state_q == ST_IDLE) ? sat_sec : cnt_sec_q;
    assign min_tens  = bcd_tens(disp_min);
    assign sec_tens  = bcd_tens(disp_sec);
    assign min_units = bcd_units(disp_min, min_tens);
    assign sec_units = bcd_units(disp_sec, sec_tens);

    // Display scan: slots 0..3 are the MM:SS digits, slot 4 hands digit 5 to the controller.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        slot_d     = slot_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            slot_d     = (slot_q == 3'd4) ? 3'd0 : slot_q + 3'd1;
        end
        an_d      = 8'hFF;
        dec_cat_d = 8'hFF;
        case (slot_q)
            3'd0: begin
                an_d      = 8'hFE;
                dec_cat_d = {seg_of(sec_units), 1'b1};
            end
            3'd1: begin
                an_d      = 8'hFD;
                dec_cat_d = {seg_of(sec_tens), 1'b1};
            end
            3'd2: begin
                an_d      = 8'hFB;
                dec_cat_d = {seg_of(min_units), 1'b0};
            end
            3'd3: begin
                an_d      = 8'hF7;
                dec_cat_d = {seg_of(min_tens), 1'b1};
            end
            default: begin
                an_d      = 8'hDF;
                dec_cat_d = 8'hFF;
            end
        endcase
    end

    assign tmr.done    = done_q;
    assign tmr.an      = an_q;
    assign tmr.dec_cat = dec_cat_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with fast tick/scan dividers.
module tb_countdown_timer;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;

    logic clock;
    logic reset;
    int   n_total;
    int   n_bad;

    countdown_timer_if tmr ();

    countdown_timer #(.TICK_DIV(10), .SCAN_DIV(2)) dut (
        .clock (clock),
        .reset (reset),
        .tmr   (tmr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start();
        tmr.start = 1'b1;
        step(1);
        tmr.start = 1'b0;
    endtask

    task automatic chk_cnt(input string tag, input logic [1:0] st, input logic [6:0] m, input logic [6:0] s);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(st));
        chk({tag, "_min"}, 32'(dut.cnt_min_q), 32'(m));
        chk({tag, "_sec"}, 32'(dut.cnt_sec_q), 32'(s));
    endtask

    logic [7:0] exp_an  [5];
    logic [7:0] exp_cat [5];

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b1;
        tmr.start = 1'b0;
        tmr.stop  = 1'b0;
        tmr.pause = 1'b0;
        tmr.min   = 7'd0;
        tmr.sec   = 7'd0;
        exp_an    = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hDF};
        exp_cat   = '{8'h99, 8'h0D, 8'h24, 8'h9F, 8'hFF};

        step(2);
        chk("rst_done", 32'(tmr.done), 32'd0);
        chk("rst_an", 32'(tmr.an), 32'hFF);
        chk("rst_cat", 32'(tmr.dec_cat), 32'hFF);
        chk_cnt("rst", S_IDLE, 7'd0, 7'd0);
        reset = 1'b0;
        step(1);

        // 1) 00:03 runs down with one done pulse
        tmr.sec = 7'd3;
        pulse_start();
        chk_cnt("t1_load", S_RUN, 7'd0, 7'd3);
        step(9);
        chk_cnt("t1_pre", S_RUN, 7'd0, 7'd3);
        step(1);
        chk_cnt("t1_tick1", S_RUN, 7'd0, 7'd2);
        step(10);
        chk_cnt("t1_tick2", S_RUN, 7'd0, 7'd1);
        step(9);
        chk("t1_done_early", 32'(tmr.done), 32'd0);
        step(1);
        chk("t1_done", 32'(tmr.done), 32'd1);
        chk_cnt("t1_end", S_IDLE, 7'd0, 7'd0);
        step(1);
        chk("t1_done_once", 32'(tmr.done), 32'd0);

        // 2) 01:00 borrows into 00:59; setpoint changes while running are ignored
        tmr.min = 7'd1;
        tmr.sec = 7'd0;
        pulse_start();
        chk_cnt("t2_load", S_RUN, 7'd1, 7'd0);
        tmr.min = 7'd5;
        step(10);
        chk_cnt("t2_tick", S_RUN, 7'd0, 7'd59);
        step(10);
        chk_cnt("t2_tick2", S_RUN, 7'd0, 7'd58);
        tmr.stop = 1'b1;
        step(1);
        tmr.stop = 1'b0;
        chk_cnt("t2_stop", S_IDLE, 7'd0, 7'd0);

        // 3) pause freezes prescaler mid-second, resume continues from it
        tmr.min = 7'd0;
        tmr.sec = 7'd5;
        pulse_start();
        step(10);
        chk_cnt("t3_tick", S_RUN, 7'd0, 7'd4);
        step(4);
        tmr.pause = 1'b1;
        step(1);
        tmr.pause = 1'b0;
        chk("t3_paused", 32'(dut.state_q), 32'(S_PAUSED));
        step(40);
        chk_cnt("t3_frozen", S_PAUSED, 7'd0, 7'd4);
        chk("t3_presc", 32'(dut.tick_cnt_q), 32'd4);
        tmr.pause = 1'b1;
        step(1);
        tmr.pause = 1'b0;
        chk("t3_resume", 32'(dut.state_q), 32'(S_RUN));
        step(5);
        chk_cnt("t3_pre", S_RUN, 7'd0, 7'd4);
        step(1);
        chk_cnt("t3_next", S_RUN, 7'd0, 7'd3);

        // 4) stop wins over pause; stop from PAUSED
        tmr.stop  = 1'b1;
        tmr.pause = 1'b1;
        step(1);
        tmr.stop  = 1'b0;
        tmr.pause = 1'b0;
        chk_cnt("t4_stop", S_IDLE, 7'd0, 7'd0);
        chk("t4_nodone", 32'(tmr.done), 32'd0);
        step(1);
        chk("t4_nodone2", 32'(tmr.done), 32'd0);
        pulse_start();
        tmr.pause = 1'b1;
        step(1);
        tmr.pause = 1'b0;
        chk_cnt("t4_pause", S_PAUSED, 7'd0, 7'd5);
        tmr.stop = 1'b1;
        step(1);
        tmr.stop = 1'b0;
        chk_cnt("t4_pstop", S_IDLE, 7'd0, 7'd0);
        chk("t4_pnodone", 32'(tmr.done), 32'd0);

        // 5) saturation and zero load
        tmr.min = 7'd120;
        tmr.sec = 7'd75;
        pulse_start();
        chk_cnt("t5_sat", S_RUN, 7'd99, 7'd59);
        tmr.stop = 1'b1;
        step(1);
        tmr.stop = 1'b0;
        tmr.min   = 7'd0;
        tmr.sec   = 7'd0;
        tmr.start = 1'b1;
        step(1);
        chk("t5_zdone", 32'(tmr.done), 32'd1);
        chk("t5_zstate", 32'(dut.state_q), 32'(S_IDLE));
        step(1);
        chk("t5_zonce", 32'(tmr.done), 32'd0);
        tmr.start = 1'b0;
        step(1);
        chk("t5_zquiet", 32'(tmr.done), 32'd0);

        // 6) live display scan of 12:34 from reset, then reset mid-run
        tmr.min = 7'd12;
        tmr.sec = 7'd34;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk($sformatf("t6_an%0d", i), 32'(tmr.an), 32'(exp_an[i % 5]));
            chk($sformatf("t6_cat%0d", i), 32'(tmr.dec_cat), 32'(exp_cat[i % 5]));
            step(1);
            chk($sformatf("t6_an%0db", i), 32'(tmr.an), 32'(exp_an[i % 5]));
        end
        pulse_start();
        step(5);
        chk_cnt("t6_run", S_RUN, 7'd12, 7'd34);
        reset = 1'b1;
        #2;
        chk("t6_rst_an", 32'(tmr.an), 32'hFF);
        chk("t6_rst_cat", 32'(tmr.dec_cat), 32'hFF);
        chk("t6_rst_done", 32'(tmr.done), 32'd0);
        chk_cnt("t6_rst", S_IDLE, 7'd0, 7'd0);
        step(1);
        reset = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
